// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store requests onto a
// byte-wide RAM port and returns little-endian words with a one-cycle completion pulse.

module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_ready,
    output logic [31:0]           if_inst,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [2:0]              len_q, len_d;
    logic [31:0]             buf_q, buf_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             if_inst_q, if_inst_d;
    logic [31:0]             ls_rdata_q, ls_rdata_d;
    logic                    if_ready_q, if_ready_d;
    logic                    ls_done_q, ls_done_d;
    logic [7:0]              hold_q;
    logic                    hold_vld_q;
    logic [7:0]              rd_byte;
    logic [2:0]              ls_len;
    logic                    stall;

    // After a freeze, mem_din already reflects the held address, so the byte that was on
    // mem_din in the first frozen cycle is kept and used at the resume edge instead.
    assign rd_byte  = hold_vld_q ? hold_q : mem_din;

    assign mem_a    = 32'(addr_q);
    assign stall    = (state_q == StStore) && io_buffer_full && (mem_a[17:16] == 2'b11);
    assign mem_wr   = (state_q == StStore) && rdy_in && !stall;
    assign mem_dout = (state_q == StStore) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

    assign if_ready = if_ready_q;
    assign if_inst  = if_inst_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

    always_comb begin
        ls_len = 3'd4;
        case (ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        buf_d      = buf_q;
        wdata_d    = wdata_q;
        if_inst_d  = if_inst_q;
        ls_rdata_d = ls_rdata_q;
        if_ready_d = 1'b0;
        ls_done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (ls_req) begin
                    state_d = ls_wr ? StStore : StLoad;
                    addr_d  = ls_addr;
                    len_d   = ls_len;
                    cnt_d   = 3'd0;
                    buf_d   = 32'h0;
                    wdata_d = ls_wdata;
                end else if (if_req && !if_flush) begin
                    state_d = StFetch;
                    addr_d  = if_addr;
                    len_d   = 3'd4;
                    cnt_d   = 3'd0;
                    buf_d   = 32'h0;
                end
            end

            StFetch, StLoad: begin
                if (state_q == StFetch && if_flush) begin
                    state_d = StIdle;
                end else begin
                    // The byte addressed in the previous cycle arrives now.
                    if (cnt_q != 3'd0) begin
                        buf_d[{2'(cnt_q - 3'd1), 3'b000} +: 8] = rd_byte;
                    end
                    if (cnt_q == len_q) begin
                        state_d = StIdle;
                        if (state_q == StFetch) begin
                            if_inst_d  = buf_d;
                            if_ready_d = 1'b1;
                        end else begin
                            ls_rdata_d = buf_d;
                            ls_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 < len_q) begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end

            StStore: begin
                if (!stall) begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d   = StIdle;
                        ls_done_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            buf_q      <= 32'h0;
            wdata_q    <= 32'h0;
            if_inst_q  <= 32'h0;
            ls_rdata_q <= 32'h0;
            if_ready_q <= 1'b0;
            ls_done_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            wdata_q    <= wdata_d;
            if_inst_q  <= if_inst_d;
            ls_rdata_q <= ls_rdata_d;
            if_ready_q <= if_ready_d;
            ls_done_q  <= ls_done_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
        end else if (!rdy_in) begin
            if (!hold_vld_q) begin
                hold_q     <= mem_din;
                hold_vld_q <= 1'b1;
            end
        end else begin
            hold_vld_q <= 1'b0;
        end
    end

endmodule
